// File: rtl/vga_capture_if.sv
// MMIO bus between the CPU (master) and the video capture block (slave).
// Picosoc-style: sel held until a one-cycle ready strobe.
interface vga_capture_if;
  logic        sel;
  logic        ready;
  logic [3:0]  wstrb;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input sel, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/vga_capture.sv
// Video input sink: samples RGB444 + HS/VS/DE, measures frame timing and
// captures one selected active line into a line buffer readable over MMIO.
module vga_capture #(
  parameter int BUF_AW = 10,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  vga_capture_if.slave bus,
  input  logic         vid_hs,
  input  logic         vid_vs,
  input  logic         vid_de,
  input  logic [11:0]  vid_rgb
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam int PW    = BUF_AW + 1;

  typedef enum logic [2:0] {IDLE, ARMED, SEEK, CAPTURE, DONE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PW-1:0] sat_inc_p(input logic [PW-1:0] v);
    return (&v) ? v : v + PW'(1);
  endfunction

  // Input stage q, then qq for edge detection
  logic        hs_q, hs_qq, vs_q, vs_qq, de_q, de_qq;
  logic [11:0] rgb_q;
  logic        hs_rise, vs_rise, de_rise, de_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q  <= 1'b0;
      hs_qq <= 1'b0;
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      de_q  <= 1'b0;
      de_qq <= 1'b0;
    end else begin
      hs_q  <= vid_hs;
      hs_qq <= hs_q;
      vs_q  <= vid_vs;
      vs_qq <= vs_q;
      de_q  <= vid_de;
      de_qq <= de_q;
    end
  end

  always_ff @(posedge clk) begin
    rgb_q <= vid_rgb;
  end

  assign hs_rise = hs_q & ~hs_qq;
  assign vs_rise = vs_q & ~vs_qq;
  assign de_rise = de_q & ~de_qq;
  assign de_fall = ~de_q & de_qq;

  // Timing measurement
  logic [CNT_W-1:0] htotal_cnt_q, htotal_cnt_d, htotal_q, htotal_d;
  logic [CNT_W-1:0] hact_cnt_q, hact_cnt_d, hactive_q, hactive_d;
  logic [CNT_W-1:0] vline_cnt_q, vline_cnt_d, vtotal_q, vtotal_d;
  logic [CNT_W-1:0] vde_cnt_q, vde_cnt_d, vactive_q, vactive_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             vs_seen_q, vs_seen_d, valid_q, valid_d;

  always_comb begin
    htotal_cnt_d = hs_rise ? CNT_W'(1) : sat_inc(htotal_cnt_q);
    htotal_d     = hs_rise ? htotal_cnt_q : htotal_q;

    hact_cnt_d = hact_cnt_q;
    if (de_fall)   hact_cnt_d = '0;
    else if (de_q) hact_cnt_d = sat_inc(hact_cnt_q);
    hactive_d = de_fall ? hact_cnt_q : hactive_q;

    // A line or DE edge coinciding with vs_rise belongs to the new frame
    vline_cnt_d = vline_cnt_q;
    if (vs_rise)      vline_cnt_d = hs_rise ? CNT_W'(1) : '0;
    else if (hs_rise) vline_cnt_d = sat_inc(vline_cnt_q);
    vtotal_d = vs_rise ? vline_cnt_q : vtotal_q;

    vde_cnt_d = vde_cnt_q;
    if (vs_rise)      vde_cnt_d = de_rise ? CNT_W'(1) : '0;
    else if (de_rise) vde_cnt_d = sat_inc(vde_cnt_q);
    vactive_d = vs_rise ? vde_cnt_q : vactive_q;

    frames_d  = vs_rise ? sat_inc(frames_q) : frames_q;
    vs_seen_d = vs_seen_q | vs_rise;
    valid_d   = valid_q | (vs_rise & vs_seen_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      htotal_cnt_q <= '0;
      htotal_q     <= '0;
      hact_cnt_q   <= '0;
      hactive_q    <= '0;
      vline_cnt_q  <= '0;
      vtotal_q     <= '0;
      vde_cnt_q    <= '0;
      vactive_q    <= '0;
      frames_q     <= '0;
      vs_seen_q    <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      htotal_cnt_q <= htotal_cnt_d;
      htotal_q     <= htotal_d;
      hact_cnt_q   <= hact_cnt_d;
      hactive_q    <= hactive_d;
      vline_cnt_q  <= vline_cnt_d;
      vtotal_q     <= vtotal_d;
      vde_cnt_q    <= vde_cnt_d;
      vactive_q    <= vactive_d;
      frames_q     <= frames_d;
      vs_seen_q    <= vs_seen_d;
      valid_q      <= valid_d;
    end
  end

  // MMIO decode
  logic              ready_q, ready_d, pend_q, pend_d;
  logic [31:0]       rdata_q, rdata_d, reg_rdata;
  logic              accept, is_wr, reg_hit, buf_hit, buf_rd;
  logic              ctrl_wr, linesel_wr, arm, ack, busy;
  logic [2:0]        reg_idx;
  logic [BUF_AW-1:0] rd_idx;
  logic [BUF_AW-1:0] linesel_q, linesel_d;
  logic              unused_bits;

  assign accept     = bus.sel & ~ready_q & ~pend_q;
  assign is_wr      = |bus.wstrb;
  assign reg_hit    = (bus.addr[23:5] == '0);
  assign buf_hit    = (bus.addr[23:22] == 2'b01) && (bus.addr[21:BUF_AW+2] == '0);
  assign reg_idx    = bus.addr[4:2];
  assign rd_idx     = bus.addr[BUF_AW+1:2];
  assign buf_rd     = accept & ~is_wr & buf_hit;
  assign ctrl_wr    = accept & is_wr & reg_hit & (reg_idx == 3'd0) & bus.wstrb[0];
  assign linesel_wr = accept & is_wr & reg_hit & (reg_idx == 3'd1);
  assign arm        = ctrl_wr & bus.wdata[0];
  assign ack        = ctrl_wr & bus.wdata[1];
  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:BUF_AW]};

  // Capture FSM
  state_t            state_q, state_d;
  logic [PW-1:0]     line_idx_q, line_idx_d, wptr_q, wptr_d, caplen_q, caplen_d;
  logic              done_q, done_d, ovf_q, ovf_d, miss_q, miss_d;
  logic              wr_en;
  logic [BUF_AW-1:0] wr_addr;
  logic [11:0]       buf_mem [DEPTH];
  logic [11:0]       ram_q;

  assign busy = (state_q == ARMED) || (state_q == SEEK) || (state_q == CAPTURE);

  always_comb begin
    state_d    = state_q;
    line_idx_d = line_idx_q;
    wptr_d     = wptr_q;
    caplen_d   = caplen_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    miss_d     = miss_q;
    wr_en      = 1'b0;
    wr_addr    = wptr_q[BUF_AW-1:0];
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = ARMED;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          miss_d  = 1'b0;
        end else if (ack && state_q == DONE) begin
          state_d = IDLE;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          miss_d  = 1'b0;
        end
      end
      ARMED: begin
        if (vs_rise) begin
          state_d    = SEEK;
          line_idx_d = '0;
        end
      end
      SEEK: begin
        if (vs_rise) begin
          state_d  = DONE;
          done_d   = 1'b1;
          miss_d   = 1'b1;
          caplen_d = '0;
        end else if (de_rise) begin
          if (line_idx_q == {1'b0, linesel_q}) begin
            state_d = CAPTURE;
            wr_en   = 1'b1;
            wr_addr = '0;
            wptr_d  = PW'(1);
          end else begin
            line_idx_d = sat_inc_p(line_idx_q);
          end
        end
      end
      CAPTURE: begin
        // de_fall is seen one stage late, so the last pixel was already written
        if (de_fall) begin
          state_d  = DONE;
          done_d   = 1'b1;
          caplen_d = wptr_q;
        end else if (de_q) begin
          if (wptr_q == PW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      line_idx_q <= '0;
      wptr_q     <= '0;
      caplen_q   <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_idx_q <= line_idx_d;
      wptr_q     <= wptr_d;
      caplen_q   <= caplen_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      miss_q     <= miss_d;
    end
  end

  // Line buffer: one write port from capture, one synchronous read port from MMIO
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_addr] <= rgb_q;
    if (buf_rd) ram_q <= buf_mem[rd_idx];
  end

  always_comb begin
    reg_rdata = '0;
    if (reg_hit) begin
      case (reg_idx)
        3'd0: reg_rdata = {27'd0, valid_q, miss_q, ovf_q, done_q, busy};
        3'd1: reg_rdata = 32'(linesel_q);
        3'd2: reg_rdata = 32'(hactive_q);
        3'd3: reg_rdata = 32'(vactive_q);
        3'd4: reg_rdata = 32'(htotal_q);
        3'd5: reg_rdata = 32'(vtotal_q);
        3'd6: reg_rdata = 32'(caplen_q);
        default: reg_rdata = 32'(frames_q);
      endcase
    end
  end

  always_comb begin
    pend_d    = buf_rd;
    ready_d   = (accept & ~buf_rd) | pend_q;
    rdata_d   = rdata_q;
    linesel_d = linesel_wr ? bus.wdata[BUF_AW-1:0] : linesel_q;
    if (pend_q)                 rdata_d = {20'd0, ram_q};
    else if (accept && !buf_rd) rdata_d = is_wr ? 32'd0 : reg_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      pend_q    <= 1'b0;
      rdata_q   <= '0;
      linesel_q <= '0;
    end else begin
      ready_q   <= ready_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
      linesel_q <= linesel_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: a 24x6 synthetic video source, MMIO
// accesses on two instances (BUF_AW=10 and BUF_AW=3 for overflow).
module tb_vga_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic        vid_hs, vid_vs, vid_de;
  logic [11:0] vid_rgb;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  vga_capture_if bus_a();
  vga_capture_if bus_b();

  vga_capture #(.BUF_AW(10), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_rgb(vid_rgb));

  vga_capture #(.BUF_AW(3), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_rgb(vid_rgb));

  task automatic vid_idle();
    vid_hs = 1'b0; vid_vs = 1'b0; vid_de = 1'b0; vid_rgb = '0;
  endtask

  // 24 clk/line: HS x=0..1, DE x=4..19; 6 lines: VS line 0, DE lines 1..4.
  // Optional abort point pulses reset for one cycle and leaves video idle.
  task automatic send_frames(input int n, input int ab_f, input int ab_l, input int ab_x);
    for (int f = 0; f < n; f++)
      for (int l = 0; l < 6; l++)
        for (int x = 0; x < 24; x++) begin
          @(negedge clk);
          if (f == ab_f && l == ab_l && x == ab_x) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            vid_idle();
            return;
          end
          vid_hs  = (x < 2);
          vid_vs  = (l == 0);
          vid_de  = (l >= 1 && l <= 4 && x >= 4 && x < 20);
          vid_rgb = vid_de ? 12'(((l - 1) << 8) | (x - 4)) : 12'd0;
        end
    @(negedge clk);
    vid_idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_access(input int which, input logic [23:0] a, input logic [3:0] strb,
                            input logic [31:0] wd, output logic [31:0] rd, output int lat);
    logic        rdy;
    logic [31:0] rdat;
    rd = '0;
    lat = -1;
    @(negedge clk);
    if (which == 0) begin
      bus_a.sel = 1'b1; bus_a.addr = a; bus_a.wstrb = strb; bus_a.wdata = wd;
    end else begin
      bus_b.sel = 1'b1; bus_b.addr = a; bus_b.wstrb = strb; bus_b.wdata = wd;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rdy  = (which == 0) ? bus_a.ready : bus_b.ready;
      rdat = (which == 0) ? bus_a.rdata : bus_b.rdata;
      if (rdy) begin
        lat = c;
        rd  = rdat;
        break;
      end
    end
    bus_a.sel = 1'b0; bus_a.wstrb = '0;
    bus_b.sel = 1'b0; bus_b.wstrb = '0;
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL bus_timeout addr=%06h: got no ready in 8 cycles, required ready", a);
    end
  endtask

  task automatic reg_rd(input int which, input logic [23:0] a, output logic [31:0] d);
    int lat;
    bus_access(which, a, 4'h0, 32'h0, d, lat);
  endtask

  task automatic reg_wr(input int which, input logic [23:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    int lat;
    bus_access(which, a, 4'hF, d, dummy, lat);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (bus_a.ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %0b want 0", bus_a.ready); end
    vectors++; if (bus_a.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %0h want 0", bus_a.rdata); end
    reset = 1'b0;
    reg_rd(0, 24'h000000, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rst_ctrl got %0h want 0", d); end
    reg_rd(0, 24'h000004, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rst_linesel got %0h want 0", d); end
    reg_rd(0, 24'h000010, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rst_htotal got %0h want 0", d); end
    reg_rd(0, 24'h00001C, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rst_frames got %0h want 0", d); end
  endtask

  task automatic test_measure();
    logic [31:0] d;
    send_frames(3, -1, 0, 0);
    reg_rd(0, 24'h000008, d); vectors++; if (d !== 32'd16) begin miscompares++; $display("FAIL hactive got %0d want 16", d); end
    reg_rd(0, 24'h000010, d); vectors++; if (d !== 32'd24) begin miscompares++; $display("FAIL htotal got %0d want 24", d); end
    reg_rd(0, 24'h00000C, d); vectors++; if (d !== 32'd4)  begin miscompares++; $display("FAIL vactive got %0d want 4", d); end
    reg_rd(0, 24'h000014, d); vectors++; if (d !== 32'd6)  begin miscompares++; $display("FAIL vtotal got %0d want 6", d); end
    reg_rd(0, 24'h00001C, d); vectors++; if (d !== 32'd3)  begin miscompares++; $display("FAIL frames got %0d want 3", d); end
    reg_rd(0, 24'h000000, d); vectors++; if (d !== 32'h10) begin miscompares++; $display("FAIL valid_ctrl got %0h want 10", d); end
  endtask

  task automatic test_capture();
    logic [31:0] d;
    reg_wr(0, 24'h000004, 32'd2);
    reg_wr(0, 24'h000000, 32'h1);
    reg_rd(0, 24'h000000, d); vectors++; if (d !== 32'h11) begin miscompares++; $display("FAIL armed_ctrl got %0h want 11", d); end
    send_frames(1, -1, 0, 0);
    reg_rd(0, 24'h000000, d); vectors++; if (d !== 32'h12) begin miscompares++; $display("FAIL cap_ctrl got %0h want 12", d); end
    reg_rd(0, 24'h000018, d); vectors++; if (d !== 32'd16) begin miscompares++; $display("FAIL cap_caplen got %0d want 16", d); end
    for (int i = 0; i < 16; i++) begin
      reg_rd(0, 24'h400000 + 24'(4 * i), d);
      vectors++;
      if (d !== 32'(32'h200 + i)) begin miscompares++; $display("FAIL cap_buf[%0d] got %0h want %0h", i, d, 32'h200 + i); end
    end
  endtask

  task automatic test_miss();
    logic [31:0] d;
    reg_wr(0, 24'h000004, 32'd7);
    reg_wr(0, 24'h000000, 32'h1);
    send_frames(2, -1, 0, 0);
    reg_rd(0, 24'h000000, d); vectors++; if (d !== 32'h1A) begin miscompares++; $display("FAIL miss_ctrl got %0h want 1a", d); end
    reg_rd(0, 24'h000018, d); vectors++; if (d !== 32'd0)  begin miscompares++; $display("FAIL miss_caplen got %0d want 0", d); end
    reg_wr(0, 24'h000000, 32'h2);
    reg_rd(0, 24'h000000, d); vectors++; if (d !== 32'h10) begin miscompares++; $display("FAIL ack_ctrl got %0h want 10", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    reg_wr(1, 24'h000004, 32'd0);
    reg_wr(1, 24'h000000, 32'h1);
    send_frames(1, -1, 0, 0);
    reg_rd(1, 24'h000000, d); vectors++; if (d !== 32'h16) begin miscompares++; $display("FAIL ovf_ctrl got %0h want 16", d); end
    reg_rd(1, 24'h000018, d); vectors++; if (d !== 32'd8)  begin miscompares++; $display("FAIL ovf_caplen got %0d want 8", d); end
    for (int i = 0; i < 8; i++) begin
      reg_rd(1, 24'h400000 + 24'(4 * i), d);
      vectors++;
      if (d !== 32'(i)) begin miscompares++; $display("FAIL ovf_buf[%0d] got %0h want %0h", i, d, i); end
    end
  endtask

  task automatic test_bus_timing();
    logic [31:0] d;
    int lat;
    @(negedge clk);
    bus_a.sel = 1'b1; bus_a.addr = 24'h000000; bus_a.wstrb = 4'h0;
    @(negedge clk);
    vectors++; if (bus_a.ready !== 1'b1 || bus_a.rdata !== 32'h10) begin miscompares++; $display("FAIL ctrl_rd_t1 got ready=%0b rdata=%0h want ready=1 rdata=10", bus_a.ready, bus_a.rdata); end
    @(negedge clk);
    vectors++; if (bus_a.ready !== 1'b0) begin miscompares++; $display("FAIL ctrl_rd_t2 got ready=%0b want 0", bus_a.ready); end
    bus_a.sel = 1'b0;
    @(negedge clk);
    vectors++; if (bus_a.ready !== 1'b0) begin miscompares++; $display("FAIL ctrl_rd_t3 got ready=%0b want 0", bus_a.ready); end
    bus_a.sel = 1'b1; bus_a.addr = 24'h400000;
    @(negedge clk);
    vectors++; if (bus_a.ready !== 1'b0) begin miscompares++; $display("FAIL buf_rd_t1 got ready=%0b want 0", bus_a.ready); end
    @(negedge clk);
    vectors++; if (bus_a.ready !== 1'b1 || bus_a.rdata !== 32'h200) begin miscompares++; $display("FAIL buf_rd_t2 got ready=%0b rdata=%0h want ready=1 rdata=200", bus_a.ready, bus_a.rdata); end
    @(negedge clk);
    vectors++; if (bus_a.ready !== 1'b0) begin miscompares++; $display("FAIL buf_rd_t3 got ready=%0b want 0", bus_a.ready); end
    bus_a.sel = 1'b0;
    bus_access(0, 24'h000010, 4'hF, 32'h1234, d, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ro_wr_lat got %0d want 1", lat); end
    bus_access(0, 24'h000010, 4'h0, 32'h0, d, lat);
    vectors++; if (d !== 32'd24 || lat !== 1) begin miscompares++; $display("FAIL ro_htotal got %0d lat %0d want 24 lat 1", d, lat); end
    reg_rd(0, 24'h000020, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_reg got %0h want 0", d); end
    reg_rd(0, 24'h000014, d);
    reg_rd(0, 24'h401000, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_buf got %0h want 0", d); end
  endtask

  task automatic test_reset_mid_capture();
    logic [31:0] d;
    reg_wr(0, 24'h000004, 32'd2);
    reg_wr(0, 24'h000000, 32'h1);
    send_frames(1, 0, 3, 10);
    repeat (2) @(negedge clk);
    reg_rd(0, 24'h000000, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL mid_rst_ctrl got %0h want 0", d); end
    reg_rd(0, 24'h000010, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL mid_rst_htotal got %0h want 0", d); end
    reg_rd(0, 24'h00001C, d); vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL mid_rst_frames got %0h want 0", d); end
    reg_rd(0, 24'h400014, d); vectors++; if (d !== 32'h205) begin miscompares++; $display("FAIL mid_rst_buf5 got %0h want 205", d); end
    reg_wr(0, 24'h000004, 32'd1);
    reg_wr(0, 24'h000000, 32'h1);
    send_frames(1, -1, 0, 0);
    reg_rd(0, 24'h000000, d); vectors++; if (d !== 32'h02) begin miscompares++; $display("FAIL rearm_ctrl got %0h want 2", d); end
    reg_rd(0, 24'h000018, d); vectors++; if (d !== 32'd16) begin miscompares++; $display("FAIL rearm_caplen got %0d want 16", d); end
    reg_rd(0, 24'h400000, d); vectors++; if (d !== 32'h100) begin miscompares++; $display("FAIL rearm_buf0 got %0h want 100", d); end
    reg_rd(0, 24'h40003C, d); vectors++; if (d !== 32'h10F) begin miscompares++; $display("FAIL rearm_buf15 got %0h want 10f", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    vid_idle();
    bus_a.sel = 1'b0; bus_a.wstrb = '0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.sel = 1'b0; bus_b.wstrb = '0; bus_b.addr = '0; bus_b.wdata = '0;
    test_reset();
    test_measure();
    test_capture();
    test_miss();
    test_overflow();
    test_bus_timing();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
